// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, LATENCY wait cycles, byte-lane merge and load extension.
// Optional macro DMEM_MISALIGN_ERR_EN turns misaligned H/W accesses into errors instead of force-aligning them.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

    logic                w_accept;
    logic                w_commit;
    logic [ADDR_W-1:0]   w_idx;
    logic [1:0]          w_lane;
    logic [31:0]         w_word;
    logic                w_illegal;
    logic                w_misalign;
    logic                w_err;
    logic                w_do_write;
    logic [31:0]         w_merged;
    logic [31:0]         w_load;
    logic                w_unused;

    // Address bits above the storage range wrap and are deliberately dropped.
    assign w_unused = ^req_addr[31:ADDR_W+2];

    function automatic logic [31:0] f_load(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  f_load = {{24{b[7]}}, b};
            3'b001:  f_load = {{16{h[15]}}, h};
            3'b010:  f_load = word;
            3'b100:  f_load = {24'h0, b};
            3'b101:  f_load = {16'h0, h};
            default: f_load = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [31:0] wdata,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  lane);
        logic [3:0]  m;
        logic [31:0] d;
        case (f3)
            3'b000: begin
                m = 4'b0001 << lane;
                d = {4{wdata[7:0]}};
            end
            3'b001: begin
                m = lane[1] ? 4'b1100 : 4'b0011;
                d = {2{wdata[15:0]}};
            end
            default: begin
                m = 4'b1111;
                d = wdata;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            f_merge[8*i +: 8] = m[i] ? d[8*i +: 8] : word[8*i +: 8];
        end
    endfunction

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[ADDR_W+1:2];
    assign w_lane   = r_addr[1:0];
    assign w_word   = r_mem[w_idx];

    always_comb begin
        w_illegal = 1'b0;
        if (r_we) begin
            w_illegal = !(r_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            w_illegal = !(r_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_misalign = ((r_funct3[1:0] == 2'b01) && w_lane[0]) ||
                        ((r_funct3 == 3'b010) && (w_lane != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err      = w_illegal || w_misalign;
    assign w_do_write = w_commit && r_we && !w_err;
    assign w_merged   = f_merge(w_word, r_wdata, r_funct3, w_lane);
    assign w_load     = f_load(w_word, r_funct3, w_lane);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Wait counter and the response registers; the response is frozen from commit until consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= 4'(LATENCY - 1);
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rdata <= (w_err || r_we) ? 32'h0 : w_load;
                r_err   <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[ADDR_W+1:0];
            r_wdata  <= req_wdata;
        end
    end

    // Read-modify-write lands on the commit edge; reset forces IDLE so an interrupted store never writes.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus backpressure and reset sequences.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full transaction; lat is the cycle in which rsp_valid is first seen, counting the
    // cycle the request is presented (closed by the accept edge) as cycle 0.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        vecs.push_back('{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 32'h0000_0010, 32'h0,         32'h0000_BEEF, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h0000_0011, 32'h1234_56AA, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0});
        vecs.push_back('{1'b1, 3'b001, 32'h0000_0012, 32'h0000_7777, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h7777_AAEF, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 3'b100, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 3'b011, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h7777_AAEF, 1'b0});
        vecs.push_back('{1'b0, 3'b111, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_1010, 32'h0000_0055, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h0000_0055, 1'b0});
`ifdef DMEM_MISALIGN_ERR_EN
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_0013, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1});
`else
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0012, 32'h0,         32'h0000_0055, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0011, 32'h0,         32'h0000_0055, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_0013, 32'h0000_0055, 32'h0000_0000, 1'b0});
`endif
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h0000_0055, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h0000_0030, 32'h0000_0080, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0030, 32'h0,         32'hFFFF_FF80, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h0000_0030, 32'h0,         32'h0000_0080, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0000, 1'b0});

        // Reset state
        #12;
        chk("reset req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_err",   {31'h0, rsp_err}, 32'h0);
        chk("reset busy",      {31'h0, busy}, 32'h0);
        #11 rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er, lat);
            chk($sformatf("v%0d rdata", i), rd, vecs[i].rd);
            chk($sformatf("v%0d err", i), {31'h0, er}, {31'h0, vecs[i].er});
            chk($sformatf("v%0d latency", i), lat, LAT + 1);
            chk($sformatf("v%0d idle after consume", i), {30'h0, rsp_valid, req_ready}, 32'h1);
        end

        // Backpressure: hold the response while a second request waits on the bus
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_we = 1'b1; req_wdata = 32'h0000_0099;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d rsp_valid", k), {31'h0, rsp_valid}, 32'h1);
            chk($sformatf("bp%0d rsp_rdata", k), rsp_rdata, 32'h0000_0055);
            chk($sformatf("bp%0d req_ready", k), {31'h0, req_ready}, 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp release rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("bp release req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp second accepted busy", {31'h0, busy}, 32'h1);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("bp second err", {31'h0, rsp_err}, 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        run_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        chk("bp second store landed", rd, 32'h0000_0099);

        // Reset during WAIT drops the pending store
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst wait rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst wait req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst wait busy",      {31'h0, busy}, 32'h0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        run_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        chk("rst wait storage kept", rd, 32'hCAFE_F00D);

        // Reset during RESP drops the response
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("resp before reset", {31'h0, rsp_valid}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rst resp rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst resp rsp_rdata", rsp_rdata, 32'h0);
        chk("rst resp req_ready", {31'h0, req_ready}, 32'h1);
        #3 rst = 1'b1;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
